// File: rtl/ro_pair_comparator.sv
// Ring-oscillator pair comparator: runs two selected ROs for a settle period and
// a counting window, counts synchronised rising edges, and reports which RO is faster.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for START; outputs hold the last report
// SETTLE | selected ROs enabled, counters frozen
// COUNT  | selected ROs enabled, synchronised rising edges counted
// DRAIN  | ROs disabled, counters frozen while the synchronisers empty
// REPORT | one-cycle DONE; RESP/ERR are valid
module ro_pair_comparator #(
  parameter int N_RO       = 16,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 8,
  parameter int IDX_W      = $clog2(N_RO)
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ABORT,
  input  logic [IDX_W-1:0] CHAL_A,
  input  logic [IDX_W-1:0] CHAL_B,
  input  logic [WIN_W-1:0] WINDOW,
  input  logic [N_RO-1:0]  RO_IN,
  output logic [N_RO-1:0]  RO_EN,
  output logic             BUSY,
  output logic             DONE,
  output logic             RESP,
  output logic [CNT_W-1:0] CNT_A,
  output logic [CNT_W-1:0] CNT_B,
  output logic             ERR
);

  localparam int ST_W  = $clog2(SETTLE_CYC + 1);
  localparam int TMR_W = (WIN_W > ST_W) ? WIN_W : ST_W;
  localparam logic [IDX_W:0] N_RO_LIM = (IDX_W + 1)'(N_RO);

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    COUNT,
    DRAIN,
    REPORT
  } state_t;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [IDX_W-1:0] chal_a_q, chal_b_q, chal_a_d, chal_b_d;
  logic [WIN_W-1:0] win_q;
  logic             req_valid, accept, cnt_en, drain_to_report;
  logic [N_RO-1:0]  sync1_q, sync2_q, sync3_q, rise;
  logic [N_RO-1:0]  sel_mask, ro_en_q;
  logic             rise_a, rise_b;
  logic [CNT_W-1:0] cnt_a_q, cnt_b_q;
  logic             ovf_a_q, ovf_b_q;
  logic             resp_q, err_q;

  assign req_valid = (CHAL_A != CHAL_B) &&
                     ({1'b0, CHAL_A} < N_RO_LIM) &&
                     ({1'b0, CHAL_B} < N_RO_LIM) &&
                     (WINDOW != '0);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  // Single down-counter times all three phases; it is reloaded on each transition.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (START && !ABORT) begin
          accept = 1'b1;
          if (req_valid) begin
            state_d = SETTLE;
            tmr_d   = TMR_W'(SETTLE_CYC - 1);
          end else begin
            state_d = REPORT;
          end
        end
      end
      SETTLE: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          state_d = COUNT;
          tmr_d   = TMR_W'(win_q) - TMR_W'(1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      COUNT: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          state_d = DRAIN;
          tmr_d   = TMR_W'(1);
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      DRAIN: begin
        if (ABORT) begin
          state_d = IDLE;
        end else if (tmr_q == '0) begin
          state_d = REPORT;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      REPORT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign chal_a_d = accept ? CHAL_A : chal_a_q;
  assign chal_b_d = accept ? CHAL_B : chal_b_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      chal_a_q <= '0;
      chal_b_q <= '0;
      win_q    <= '0;
    end else if (accept) begin
      chal_a_q <= CHAL_A;
      chal_b_q <= CHAL_B;
      win_q    <= WINDOW;
    end
  end

  // RO_EN is registered from the next state so the analog enables never see decode glitches.
  assign sel_mask = (N_RO'(1) << chal_a_d) | (N_RO'(1) << chal_b_d);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ro_en_q <= '0;
    end else if (state_d == SETTLE || state_d == COUNT) begin
      ro_en_q <= sel_mask;
    end else begin
      ro_en_q <= '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= RO_IN;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign rise   = sync2_q & ~sync3_q;
  assign rise_a = rise[chal_a_q];
  assign rise_b = rise[chal_b_q];

  // An aborting cycle does not count, so the aborted counts stay as they were.
  assign cnt_en = (state_q == COUNT) && !ABORT;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
    end else if (accept) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
      ovf_a_q <= 1'b0;
      ovf_b_q <= 1'b0;
    end else if (cnt_en) begin
      if (rise_a) begin
        if (&cnt_a_q) ovf_a_q <= 1'b1;
        else          cnt_a_q <= cnt_a_q + CNT_W'(1);
      end
      if (rise_b) begin
        if (&cnt_b_q) ovf_b_q <= 1'b1;
        else          cnt_b_q <= cnt_b_q + CNT_W'(1);
      end
    end
  end

  assign drain_to_report = (state_q == DRAIN) && (state_d == REPORT);

  // RESP is left alone at acceptance so an aborted run still shows the previous answer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      resp_q <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      err_q <= ~req_valid;
      if (!req_valid) resp_q <= 1'b0;
    end else if (drain_to_report) begin
      resp_q <= (cnt_a_q > cnt_b_q);
      err_q  <= ovf_a_q | ovf_b_q;
    end
  end

  assign RO_EN = ro_en_q;
  assign BUSY  = (state_q != IDLE);
  assign DONE  = (state_q == REPORT);
  assign RESP  = resp_q;
  assign CNT_A = cnt_a_q;
  assign CNT_B = cnt_b_q;
  assign ERR   = err_q;

endmodule

// File: tb/tb_ro_pair_comparator.sv
// Randomised bench for ro_pair_comparator: free-running RO patterns, a wide-counter
// instance and a 4-bit-counter instance compared against an edge-counting model.
module tb_ro_pair_comparator;

  localparam int S    = 8;
  localparam int SMAX = 15;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic        ABORT = 1'b0;
  logic [3:0]  CHAL_A = '0;
  logic [3:0]  CHAL_B = '0;
  logic [15:0] WINDOW = '0;
  logic [15:0] RO_IN = '0;

  logic [15:0] RO_EN, RO_EN_S;
  logic        BUSY, DONE, RESP, ERR;
  logic        BUSY_S, DONE_S, RESP_S, ERR_S;
  logic [15:0] CNT_A, CNT_B;
  logic [3:0]  CNT_A_S, CNT_B_S;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int per[16];
  int ph[16];
  logic resp_prev = 1'b0;
  logic resp_prev_s = 1'b0;

  ro_pair_comparator #(.N_RO(16), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(S), .IDX_W(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .CHAL_A(CHAL_A), .CHAL_B(CHAL_B), .WINDOW(WINDOW), .RO_IN(RO_IN),
    .RO_EN(RO_EN), .BUSY(BUSY), .DONE(DONE), .RESP(RESP),
    .CNT_A(CNT_A), .CNT_B(CNT_B), .ERR(ERR)
  );

  ro_pair_comparator #(.N_RO(16), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(S), .IDX_W(4)) dut_s (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .CHAL_A(CHAL_A), .CHAL_B(CHAL_B), .WINDOW(WINDOW), .RO_IN(RO_IN),
    .RO_EN(RO_EN_S), .BUSY(BUSY_S), .DONE(DONE_S), .RESP(RESP_S),
    .CNT_A(CNT_A_S), .CNT_B(CNT_B_S), .ERR(ERR_S)
  );

  initial forever #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Level of RO ch as sampled by posedge number e.
  function automatic logic ro_val(input int ch, input int e);
    return ((e + ph[ch]) % per[ch]) < (per[ch] / 2);
  endfunction

  initial forever begin
    @(negedge CLK);
    for (int i = 0; i < 16; i++) RO_IN[i] = ro_val(i, cyc + 1);
  end

  // Rising edges seen by a 2-flop synchroniser + detector and counted at edges k+S+1 .. k+hi.
  function automatic int count_rises(input int ch, input int k, input int hi);
    int n = 0;
    for (int e = k + S - 1; e <= k + hi - 2; e++)
      if (ro_val(ch, e) && !ro_val(ch, e - 1)) n++;
    return n;
  endfunction

  function automatic int sat(input int n);
    return (n > SMAX) ? SMAX : n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 32'(BUSY), 32'(0));
    chk({tag, "_done"}, 32'(DONE), 32'(0));
    chk({tag, "_resp"}, 32'(RESP), 32'(0));
    chk({tag, "_err"},  32'(ERR),  32'(0));
    chk({tag, "_cnta"}, 32'(CNT_A), 32'(0));
    chk({tag, "_cntb"}, 32'(CNT_B), 32'(0));
    chk({tag, "_roen"}, 32'(RO_EN), 32'(0));
    chk({tag, "_roen_s"}, 32'(RO_EN_S), 32'(0));
    chk({tag, "_busy_s"}, 32'(BUSY_S), 32'(0));
    chk({tag, "_cnta_s"}, 32'(CNT_A_S), 32'(0));
  endtask

  task automatic rand_ros();
    for (int i = 0; i < 16; i++) begin
      per[i] = $urandom_range(2, 9);
      ph[i]  = $urandom_range(0, per[i] - 1);
    end
  endtask

  // mode: 0 plain, 1 START pulse while busy at offset 'at', 2 ABORT at 'at', 3 reset at 'at'
  task automatic run_txn(input int a, input int b, input int w, input int mode, input int at);
    bit valid;
    int k, done_off, last, hi, na, nb, ca, cb, csa, csb;
    logic er, ee, ers, ees;
    logic [15:0] mask;
    valid    = (a != b) && (w != 0);
    done_off = valid ? S + w + 2 : 0;
    last     = (mode >= 2) ? at : done_off;
    hi       = (mode == 2 && at < S + w) ? at : S + w;
    mask     = 16'(1 << a) | 16'(1 << b);
    @(negedge CLK);
    CHAL_A = 4'(a);
    CHAL_B = 4'(b);
    WINDOW = 16'(w);
    START  = 1'b1;
    k = cyc + 1;
    na = valid ? count_rises(a, k, hi) : 0;
    nb = valid ? count_rises(b, k, hi) : 0;
    if (mode == 3) begin
      er = 0; ee = 0; ers = 0; ees = 0; ca = 0; cb = 0; csa = 0; csb = 0;
    end else if (mode == 2) begin
      er = resp_prev; ee = 0; ers = resp_prev_s; ees = 0;
      ca = na; cb = nb; csa = sat(na); csb = sat(nb);
    end else begin
      ca = na; cb = nb; csa = sat(na); csb = sat(nb);
      er  = valid && (na > nb);
      ee  = !valid;
      ers = valid && (csa > csb);
      ees = !valid || (na > SMAX) || (nb > SMAX);
    end
    for (int j = 0; j <= last + 3; j++) begin
      @(negedge CLK);
      START = 1'b0;
      ABORT = 1'b0;
      RST_N = 1'b1;
      chk("busy", 32'(BUSY), 32'(j <= last));
      chk("done", 32'(DONE), 32'(mode < 2 && j == done_off));
      chk("done_s", 32'(DONE_S), 32'(mode < 2 && j == done_off));
      chk("ro_en", 32'(RO_EN), 32'((valid && j < S + w && j <= last) ? mask : 16'h0));
      chk("ro_en_s", 32'(RO_EN_S), 32'((valid && j < S + w && j <= last) ? mask : 16'h0));
      if ((mode < 2 && (j == done_off || j == done_off + 3)) || (mode >= 2 && j == last + 1)) begin
        chk("resp", 32'(RESP), 32'(er));
        chk("err", 32'(ERR), 32'(ee));
        chk("cnt_a", 32'(CNT_A), 32'(ca));
        chk("cnt_b", 32'(CNT_B), 32'(cb));
        chk("resp_s", 32'(RESP_S), 32'(ers));
        chk("err_s", 32'(ERR_S), 32'(ees));
        chk("cnt_a_s", 32'(CNT_A_S), 32'(csa));
        chk("cnt_b_s", 32'(CNT_B_S), 32'(csb));
      end
      if (mode == 1 && j == at) begin
        START  = 1'b1;
        CHAL_A = 4'($urandom_range(0, 15));
        WINDOW = 16'($urandom_range(1, 30));
      end
      if (mode == 2 && j == at) ABORT = 1'b1;
      if (mode == 3 && j == at) begin
        #2 RST_N = 1'b0;
        #1 chk_all_zero("rst_mid");
      end
    end
    resp_prev   = er;
    resp_prev_s = ers;
  endtask

  initial begin
    int a, b, w, m, at;
    for (int i = 0; i < 16; i++) begin
      per[i] = 6;
      ph[i]  = i % 6;
    end
    @(negedge CLK);
    chk_all_zero("in_reset");
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk_all_zero("after_reset");

    per[3] = 4; ph[3] = 0;
    per[7] = 5; ph[7] = 2;
    run_txn(3, 7, 100, 0, 0);
    run_txn(5, 5, 50, 0, 0);
    run_txn(2, 9, 0, 0, 0);
    per[1] = 6; ph[1] = 1;
    per[6] = 6; ph[6] = 1;
    run_txn(1, 6, 80, 0, 0);
    per[1] = 2; ph[1] = 0;
    per[2] = 9; ph[2] = 4;
    run_txn(1, 2, 100, 0, 0);
    run_txn(7, 3, 100, 2, S + 9);
    run_txn(3, 7, 100, 3, S + 20);
    repeat (3) @(negedge CLK);

    @(negedge CLK);
    CHAL_A = 4'd2; CHAL_B = 4'd5; WINDOW = 16'd10;
    START = 1'b1; ABORT = 1'b1;
    @(negedge CLK);
    START = 1'b0; ABORT = 1'b0;
    chk("sa_busy", 32'(BUSY), 32'(0));
    chk("sa_roen", 32'(RO_EN), 32'(0));
    @(negedge CLK);
    chk("sa_done", 32'(DONE), 32'(0));

    run_txn(4, 11, 40, 1, S + 5);

    for (int t = 0; t < 25; t++) begin
      rand_ros();
      a = $urandom_range(0, 15);
      b = ($urandom_range(0, 7) == 0) ? a : int'($urandom_range(0, 15));
      w = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 60));
      m = $urandom_range(0, 9);
      if (a == b || w == 0) begin
        run_txn(a, b, w, 0, 0);
      end else begin
        at = $urandom_range(0, S + w + 1);
        if (m < 2)       run_txn(a, b, w, 2, at);
        else if (m == 2) run_txn(a, b, w, 1, at);
        else             run_txn(a, b, w, 0, 0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
